// File: rtl/io_dec_pkg.sv
// ---------------------------------------------------------------------------
// io_dec_pkg
// Shared definitions for the I/O read decoder with wait-state support.
//   - Fixed I/O addresses of the registers served inside the core
//   - State type of the wait-state FSM
//   - win_hit(): masked address compare used by every peripheral window
// ---------------------------------------------------------------------------
package io_dec_pkg;

    localparam logic [5:0] ADR_SREG  = 6'h3F;
    localparam logic [5:0] ADR_SPH   = 6'h3E;
    localparam logic [5:0] ADR_SPL   = 6'h3D;
    localparam logic [5:0] ADR_EIND  = 6'h3C;
    localparam logic [5:0] ADR_RAMPZ = 6'h3B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TMO  = 2'd2
    } io_ws_st_t;

    // A window hits when the address bits selected by mask equal the base.
    function automatic logic win_hit(input logic [5:0] adr,
                                     input logic [5:0] base,
                                     input logic [5:0] mask);
        return (adr & mask) == base;
    endfunction

endpackage

// File: rtl/io_wait_fsm.sv
// ---------------------------------------------------------------------------
// io_wait_fsm
// Wait-state handshake for reads from external peripheral windows.
// A read that hits a window whose ext_rdy is low stalls the core until the
// window reports ready, the core drops iore, or the wait counter expires.
//
// Ports
//   cp2      in   core clock
//   ireset   in   synchronous reset, active-high
//   iore     in   I/O read strobe
//   ext_hit  in   current address hits an external window (not internal)
//   hit_idx  in   index of the highest-priority window that hits
//   ext_rdy  in   per-window data-valid
//   state    out  current FSM state
//   win_idx  out  window being served (latched one while waiting)
//   io_stall out  core must hold the access
//   io_err   out  one-cycle pulse: read timed out
// ---------------------------------------------------------------------------
module io_wait_fsm
    import io_dec_pkg::*;
#(
    parameter int N_EXT    = 4,
    parameter int WAIT_TMO = 16,
    parameter int IW       = (N_EXT > 1) ? $clog2(N_EXT) : 1
) (
    input  logic             cp2,
    input  logic             ireset,
    input  logic             iore,
    input  logic             ext_hit,
    input  logic [IW-1:0]    hit_idx,
    input  logic [N_EXT-1:0] ext_rdy,
    output io_ws_st_t        state,
    output logic [IW-1:0]    win_idx,
    output logic             io_stall,
    output logic             io_err
);

    // Counter is wide enough to reach WAIT_TMO; with the timeout disabled a
    // single saturating bit is kept so the logic stays uniform.
    localparam int            CW      = (WAIT_TMO > 0) ? $clog2(WAIT_TMO + 1) : 1;
    localparam logic [CW-1:0] TMO_CNT = CW'(WAIT_TMO);
    localparam bit            TMO_EN  = (WAIT_TMO != 0);

    io_ws_st_t     st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] win_q, win_d;
    logic          rdy_new;
    logic          rdy_held;

    assign rdy_new  = ext_rdy[hit_idx];
    assign rdy_held = ext_rdy[win_q];
    assign state    = st_q;

    // State register
    always_ff @(posedge cp2) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (ireset) begin
            st_q  <= IDLE;
            cnt_q <= '0;
            win_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            win_q <= win_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        st_d  = st_q;
        cnt_d = cnt_q;
        win_d = win_q;
        case (st_q)
            IDLE: begin
                if (iore && ext_hit && !rdy_new) begin
                    st_d  = WAIT;
                    cnt_d = CW'(1);
                    win_d = hit_idx;
                end
            end
            WAIT: begin
                if (!iore || rdy_held) begin
                    st_d  = IDLE;
                    cnt_d = '0;
                end else if (TMO_EN && (cnt_q == TMO_CNT)) begin
                    st_d  = TMO;
                    cnt_d = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TMO: begin
                st_d = IDLE;
            end
            default: begin
                st_d  = IDLE;
                cnt_d = '0;
            end
        endcase
    end

    // Outputs: stall is combinational so the core freezes in the very cycle
    // the slow window is first addressed.
    always_comb begin
        io_stall = 1'b0;
        io_err   = 1'b0;
        win_idx  = hit_idx;
        if (!ireset) begin
            case (st_q)
                IDLE: io_stall = iore && ext_hit && !rdy_new;
                WAIT: begin
                    io_stall = iore && !rdy_held;
                    if (iore) win_idx = win_q;
                end
                TMO:  io_err = 1'b1;
                default: io_stall = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/io_adr_dec_ws.sv
// ---------------------------------------------------------------------------
// io_adr_dec_ws
// I/O read decoder / multiplexer for the AVR core with wait-state support.
// Serves SPL/SPH/SREG, owns RAMPZ and (optionally) EIND, routes N_EXT
// peripheral windows with one-hot selects and stalls the core on slow reads.
//
// Ports
//   cp2         in   core clock
//   ireset      in   synchronous reset, active-high
//   adr         in   6-bit I/O address
//   iore/iowe   in   I/O read / write strobes
//   dbusout     in   core write data
//   dbusin_int  out  read data to core
//   io_stall    out  core must hold adr/iore and freeze
//   io_err      out  one-cycle pulse: read timed out (data reads 8'hFF)
//   spl_out/sph_out/sreg_out  in  stack pointer / status register values
//   rampz_out   out  RAMPZ register, tied to zero when RAMPZ_EN=0
//   eind_out    out  EIND register, tied to zero when PC22B=0
//   dbusin_ext  in   catch-all external read bus
//   ext_sel     out  one-hot window select, qualified by iore|iowe
//   ext_dat     in   packed per-window read data
//   ext_rdy     in   per-window data-valid
// ---------------------------------------------------------------------------
module io_adr_dec_ws
    import io_dec_pkg::*;
#(
    parameter bit                 PC22B      = 1'b0,
    parameter bit                 RAMPZ_EN   = 1'b1,
    parameter logic [7:0]         RAMPZ_MASK = 8'h01,
    parameter int                 N_EXT      = 4,
    parameter logic [6*N_EXT-1:0] EXT_BASE   = {N_EXT{6'h00}},
    parameter logic [6*N_EXT-1:0] EXT_MASK   = {N_EXT{6'h3F}},
    parameter int                 WAIT_TMO   = 16
) (
    input  logic               cp2,
    input  logic               ireset,
    input  logic [5:0]         adr,
    input  logic               iore,
    input  logic               iowe,
    input  logic [7:0]         dbusout,
    output logic [7:0]         dbusin_int,
    output logic               io_stall,
    output logic               io_err,
    input  logic [7:0]         spl_out,
    input  logic [7:0]         sph_out,
    input  logic [7:0]         sreg_out,
    output logic [7:0]         rampz_out,
    output logic [7:0]         eind_out,
    input  logic [7:0]         dbusin_ext,
    output logic [N_EXT-1:0]   ext_sel,
    input  logic [8*N_EXT-1:0] ext_dat,
    input  logic [N_EXT-1:0]   ext_rdy
);

    localparam int IW = (N_EXT > 1) ? $clog2(N_EXT) : 1;

    logic [N_EXT-1:0] win_hits;
    logic             any_hit;
    logic             is_int;
    logic             ext_hit;
    logic [IW-1:0]    hit_idx;
    logic [IW-1:0]    win_idx;
    io_ws_st_t        state;

    // ---------------- Address decode ----------------
    always_comb begin
        is_int = (adr == ADR_SREG) || (adr == ADR_SPH) || (adr == ADR_SPL)
              || (PC22B    && (adr == ADR_EIND))
              || (RAMPZ_EN && (adr == ADR_RAMPZ));
    end

    always_comb begin
        for (int i = 0; i < N_EXT; i++) begin
            win_hits[i] = win_hit(adr, EXT_BASE[6*i +: 6], EXT_MASK[6*i +: 6]);
        end
    end

    // Scan from the top so the lowest-indexed hit is the one that sticks.
    always_comb begin
        hit_idx = '0;
        any_hit = 1'b0;
        for (int i = N_EXT - 1; i >= 0; i--) begin
            if (win_hits[i]) begin
                hit_idx = IW'(i);
                any_hit = 1'b1;
            end
        end
    end

    // Internal registers always win over overlapping windows.
    assign ext_hit = any_hit && !is_int;

    // ---------------- Wait-state FSM ----------------
    io_wait_fsm #(
        .N_EXT    (N_EXT),
        .WAIT_TMO (WAIT_TMO),
        .IW       (IW)
    ) u_fsm (
        .cp2      (cp2),
        .ireset   (ireset),
        .iore     (iore),
        .ext_hit  (ext_hit),
        .hit_idx  (hit_idx),
        .ext_rdy  (ext_rdy),
        .state    (state),
        .win_idx  (win_idx),
        .io_stall (io_stall),
        .io_err   (io_err)
    );

    // ---------------- Locally owned registers ----------------
    generate
        if (RAMPZ_EN) begin : g_rampz
            logic [7:0] rampz_q;
            always_ff @(posedge cp2) begin
                if (ireset) begin
                    rampz_q <= 8'h00;
                end else if (iowe && (adr == ADR_RAMPZ)) begin
                    rampz_q <= dbusout & RAMPZ_MASK;
                end
            end
            assign rampz_out = rampz_q;
        end else begin : g_no_rampz
            assign rampz_out = 8'h00;
        end

        if (PC22B) begin : g_eind
            logic [7:0] eind_q;
            always_ff @(posedge cp2) begin
                if (ireset) begin
                    eind_q <= 8'h00;
                end else if (iowe && (adr == ADR_EIND)) begin
                    eind_q <= dbusout;
                end
            end
            assign eind_out = eind_q;
        end else begin : g_no_eind
            assign eind_out = 8'h00;
        end
    endgenerate

    // ---------------- Window select ----------------
    // While waiting, the select follows the window latched at WAIT entry.
    always_comb begin
        ext_sel = '0;
        if (!ireset && (iore || iowe) && (ext_hit || (state == WAIT && iore))) begin
            ext_sel[win_idx] = 1'b1;
        end
    end

    // ---------------- Read multiplexer ----------------
    always_comb begin
        dbusin_int = dbusin_ext;
        if (!ireset && iore) begin
            if (state == TMO) begin
                dbusin_int = 8'hFF;
            end else if (state == WAIT) begin
                dbusin_int = ext_dat[{win_idx, 3'b000} +: 8];
            end else if (adr == ADR_SREG) begin
                dbusin_int = sreg_out;
            end else if (adr == ADR_SPH) begin
                dbusin_int = sph_out;
            end else if (adr == ADR_SPL) begin
                dbusin_int = spl_out;
            end else if (PC22B && (adr == ADR_EIND)) begin
                dbusin_int = eind_out;
            end else if (RAMPZ_EN && (adr == ADR_RAMPZ)) begin
                dbusin_int = rampz_out;
            end else if (ext_hit) begin
                dbusin_int = ext_dat[{win_idx, 3'b000} +: 8];
            end
        end
    end

endmodule

// File: tb/tb_io_adr_dec_ws.sv
// ---------------------------------------------------------------------------
// tb_io_adr_dec_ws
// Self-checking bench for io_adr_dec_ws. Main instance: PC22B=0, RAMPZ on,
// WAIT_TMO=4, windows w0=0x10-0x13, w1=0x20, w2=0x12-0x13, w3=0x38-0x3B.
// Second instance shares all inputs: PC22B=1, no RAMPZ, timeout disabled.
// ---------------------------------------------------------------------------
module tb_io_adr_dec_ws;

    localparam logic [23:0] BASES = {6'h38, 6'h12, 6'h20, 6'h10};
    localparam logic [23:0] MASKS = {6'h3C, 6'h3E, 6'h3F, 6'h3C};

    logic        cp2;
    logic        ireset;
    logic [5:0]  adr;
    logic        iore;
    logic        iowe;
    logic [7:0]  dbusout;
    logic [7:0]  spl_out;
    logic [7:0]  sph_out;
    logic [7:0]  sreg_out;
    logic [7:0]  dbusin_ext;
    logic [31:0] ext_dat;
    logic [3:0]  ext_rdy;

    logic [7:0]  dbusin_int;
    logic        io_stall;
    logic        io_err;
    logic [7:0]  rampz_out;
    logic [7:0]  eind_out;
    logic [3:0]  ext_sel;

    logic [7:0]  d2_dbus;
    logic        d2_stall;
    logic        d2_err;
    logic [7:0]  d2_rampz;
    logic [7:0]  d2_eind;
    logic [3:0]  d2_sel;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_rampz;

    typedef struct {
        string      tag;
        bit         dv;
        logic [7:0] dbus;
        logic       stall;
        logic       err;
        logic [3:0] sel;
        logic [7:0] rampz;
        logic [7:0] eind;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    io_adr_dec_ws #(
        .PC22B(1'b0), .RAMPZ_EN(1'b1), .RAMPZ_MASK(8'h01), .N_EXT(4),
        .EXT_BASE(BASES), .EXT_MASK(MASKS), .WAIT_TMO(4)
    ) dut (
        .cp2(cp2), .ireset(ireset), .adr(adr), .iore(iore), .iowe(iowe),
        .dbusout(dbusout), .dbusin_int(dbusin_int), .io_stall(io_stall),
        .io_err(io_err), .spl_out(spl_out), .sph_out(sph_out),
        .sreg_out(sreg_out), .rampz_out(rampz_out), .eind_out(eind_out),
        .dbusin_ext(dbusin_ext), .ext_sel(ext_sel), .ext_dat(ext_dat),
        .ext_rdy(ext_rdy)
    );

    io_adr_dec_ws #(
        .PC22B(1'b1), .RAMPZ_EN(1'b0), .RAMPZ_MASK(8'h01), .N_EXT(4),
        .EXT_BASE(BASES), .EXT_MASK(MASKS), .WAIT_TMO(0)
    ) dut2 (
        .cp2(cp2), .ireset(ireset), .adr(adr), .iore(iore), .iowe(iowe),
        .dbusout(dbusout), .dbusin_int(d2_dbus), .io_stall(d2_stall),
        .io_err(d2_err), .spl_out(spl_out), .sph_out(sph_out),
        .sreg_out(sreg_out), .rampz_out(d2_rampz), .eind_out(d2_eind),
        .dbusin_ext(dbusin_ext), .ext_sel(d2_sel), .ext_dat(ext_dat),
        .ext_rdy(ext_rdy)
    );

    initial cp2 = 1'b0;
    always #5 cp2 = ~cp2;

    // Scoreboard monitor: pops one expectation per cycle, mid-cycle.
    always @(negedge cp2) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            if (mon_e.dv) begin
                checks++;
                if (dbusin_int !== mon_e.dbus) begin
                    errors++;
                    $display("FAIL %s dbusin_int got %h expected %h", mon_e.tag, dbusin_int, mon_e.dbus);
                end
            end
            checks++;
            if (io_stall !== mon_e.stall) begin
                errors++;
                $display("FAIL %s io_stall got %b expected %b", mon_e.tag, io_stall, mon_e.stall);
            end
            checks++;
            if (io_err !== mon_e.err) begin
                errors++;
                $display("FAIL %s io_err got %b expected %b", mon_e.tag, io_err, mon_e.err);
            end
            checks++;
            if (ext_sel !== mon_e.sel) begin
                errors++;
                $display("FAIL %s ext_sel got %b expected %b", mon_e.tag, ext_sel, mon_e.sel);
            end
            checks++;
            if (rampz_out !== mon_e.rampz) begin
                errors++;
                $display("FAIL %s rampz_out got %h expected %h", mon_e.tag, rampz_out, mon_e.rampz);
            end
            checks++;
            if (eind_out !== mon_e.eind) begin
                errors++;
                $display("FAIL %s eind_out got %h expected %h", mon_e.tag, eind_out, mon_e.eind);
            end
        end
    end

    // Push the expectation for the cycle just driven, advance one clock and
    // update the RAMPZ model from the inputs seen at the edge.
    task automatic cyc(input string tag, input bit dv, input logic [7:0] d,
                       input logic st, input logic er, input logic [3:0] sel);
        exp_t e;
        e.tag = tag; e.dv = dv; e.dbus = d; e.stall = st; e.err = er;
        e.sel = sel; e.rampz = m_rampz; e.eind = 8'h00;
        sb.push_back(e);
        @(posedge cp2);
        if (ireset) m_rampz = 8'h00;
        else if (iowe && adr == 6'h3B) m_rampz = dbusout & 8'h01;
        #1;
    endtask

    task automatic test_reset();
        ireset = 1'b1; iore = 1'b1; adr = 6'h12; ext_rdy = 4'b0000;
        #1;
        checks++;
        if (d2_stall !== 1'b0 || d2_sel !== 4'b0000) begin
            errors++;
            $display("FAIL reset_dut2 stall/sel got %b/%b expected 0/0000", d2_stall, d2_sel);
        end
        cyc("reset", 1, 8'hC3, 1'b0, 1'b0, 4'b0000);
        ireset = 1'b0; iore = 1'b0; ext_rdy = 4'b1111;
        cyc("post_reset", 1, 8'hC3, 1'b0, 1'b0, 4'b0000);
    endtask

    task automatic test_internal_read();
        logic [5:0] a [6] = '{6'h3F, 6'h3E, 6'h3D, 6'h3C, 6'h3B, 6'h3A};
        logic [7:0] d [6] = '{8'hA5, 8'h22, 8'h11, 8'hC3, 8'h00, 8'h44};
        logic [3:0] s [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
        iore = 1'b1;
        for (int i = 0; i < 6; i++) begin
            adr = a[i];
            cyc($sformatf("int_rd_%h", a[i]), 1, d[i], 1'b0, 1'b0, s[i]);
        end
        // Without RAMPZ, 0x3B belongs to window 3 in the second instance.
        adr = 6'h3B;
        #1;
        checks++;
        if (d2_dbus !== 8'h44 || d2_sel !== 4'b1000) begin
            errors++;
            $display("FAIL dut2_3b_window dbus/sel got %h/%b expected 44/1000", d2_dbus, d2_sel);
        end
        cyc("int_rd_3b_again", 1, 8'h00, 1'b0, 1'b0, 4'b0000);
        iore = 1'b0;
    endtask

    task automatic test_rampz_write();
        iore = 1'b0; iowe = 1'b1; adr = 6'h3B; dbusout = 8'hFF;
        cyc("rampz_wr_ff", 1, 8'hC3, 1'b0, 1'b0, 4'b0000);
        iowe = 1'b0; iore = 1'b1;
        cyc("rampz_rd_01", 1, 8'h01, 1'b0, 1'b0, 4'b0000);
        iowe = 1'b1; dbusout = 8'hFE;
        cyc("rampz_rw_fe", 1, 8'h01, 1'b0, 1'b0, 4'b0000);
        iowe = 1'b0;
        cyc("rampz_rd_00", 1, 8'h00, 1'b0, 1'b0, 4'b0000);
        iore = 1'b0; iowe = 1'b1; dbusout = 8'h03;
        cyc("rampz_wr_03", 1, 8'hC3, 1'b0, 1'b0, 4'b0000);
        iowe = 1'b0;
        #1;
        checks++;
        if (d2_rampz !== 8'h00) begin
            errors++;
            $display("FAIL dut2_rampz_tied got %h expected 00", d2_rampz);
        end
        cyc("rampz_idle", 1, 8'hC3, 1'b0, 1'b0, 4'b0000);
    endtask

    task automatic test_eind();
        iowe = 1'b1; adr = 6'h3C; dbusout = 8'h9C;
        #1;
        checks++;
        if (d2_sel !== 4'b0000) begin
            errors++;
            $display("FAIL dut2_eind_sel got %b expected 0000", d2_sel);
        end
        cyc("eind_wr", 1, 8'hC3, 1'b0, 1'b0, 4'b0000);
        iowe = 1'b0; iore = 1'b1;
        #1;
        checks++;
        if (d2_dbus !== 8'h9C || d2_eind !== 8'h9C) begin
            errors++;
            $display("FAIL dut2_eind_rd dbus/eind got %h/%h expected 9c/9c", d2_dbus, d2_eind);
        end
        cyc("eind_rd_default", 1, 8'hC3, 1'b0, 1'b0, 4'b0000);
        iore = 1'b0;
    endtask

    task automatic test_ext_wait();
        iore = 1'b1; adr = 6'h12; ext_rdy = 4'b1110; ext_dat[7:0] = 8'h00;
        for (int i = 0; i < 3; i++) cyc($sformatf("wait_stall_%0d", i), 0, 8'h00, 1'b1, 1'b0, 4'b0001);
        ext_rdy = 4'b1111; ext_dat[7:0] = 8'h5A;
        cyc("wait_rdy", 1, 8'h5A, 1'b0, 1'b0, 4'b0001);
        iore = 1'b0;
        cyc("wait_done", 1, 8'hC3, 1'b0, 1'b0, 4'b0000);
    endtask

    task automatic test_abort();
        iore = 1'b1; adr = 6'h10; ext_rdy = 4'b1110;
        cyc("abort_stall_0", 0, 8'h00, 1'b1, 1'b0, 4'b0001);
        cyc("abort_stall_1", 0, 8'h00, 1'b1, 1'b0, 4'b0001);
        iore = 1'b0;
        cyc("abort_drop", 1, 8'hC3, 1'b0, 1'b0, 4'b0000);
        cyc("abort_quiet", 1, 8'hC3, 1'b0, 1'b0, 4'b0000);
        iore = 1'b1; ext_rdy = 4'b1111;
        cyc("abort_next", 1, 8'h5A, 1'b0, 1'b0, 4'b0001);
        iore = 1'b0;
    endtask

    task automatic test_timeout();
        iore = 1'b1; adr = 6'h20; ext_rdy = 4'b1101;
        for (int i = 0; i < 5; i++) cyc($sformatf("tmo_stall_%0d", i), 0, 8'h00, 1'b1, 1'b0, 4'b0010);
        #1;
        checks++;
        if (d2_stall !== 1'b1 || d2_err !== 1'b0) begin
            errors++;
            $display("FAIL dut2_no_timeout stall/err got %b/%b expected 1/0", d2_stall, d2_err);
        end
        cyc("tmo_pulse", 1, 8'hFF, 1'b0, 1'b1, 4'b0010);
        iore = 1'b0;
        #1;
        checks++;
        if (d2_stall !== 1'b0) begin
            errors++;
            $display("FAIL dut2_drop_stall got %b expected 0", d2_stall);
        end
        cyc("tmo_after", 1, 8'hC3, 1'b0, 1'b0, 4'b0000);
        ext_rdy = 4'b1111;
    endtask

    task automatic test_back_to_back();
        iore = 1'b1; ext_rdy = 4'b1111;
        adr = 6'h13; cyc("b2b_overlap", 1, 8'h5A, 1'b0, 1'b0, 4'b0001);
        adr = 6'h20; cyc("b2b_w1", 1, 8'h22, 1'b0, 1'b0, 4'b0010);
        adr = 6'h3A; cyc("b2b_w3", 1, 8'h44, 1'b0, 1'b0, 4'b1000);
        adr = 6'h3F; cyc("b2b_sreg", 1, 8'hA5, 1'b0, 1'b0, 4'b0000);
        iore = 1'b0; iowe = 1'b1; dbusout = 8'h00;
        adr = 6'h20; cyc("b2b_ext_wr", 1, 8'hC3, 1'b0, 1'b0, 4'b0010);
        adr = 6'h3E; cyc("b2b_sph_wr", 1, 8'hC3, 1'b0, 1'b0, 4'b0000);
        iowe = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        iore = 1'b1; adr = 6'h12; ext_rdy = 4'b1110;
        cyc("rmw_stall_0", 0, 8'h00, 1'b1, 1'b0, 4'b0001);
        cyc("rmw_stall_1", 0, 8'h00, 1'b1, 1'b0, 4'b0001);
        ireset = 1'b1;
        cyc("rmw_reset", 1, 8'hC3, 1'b0, 1'b0, 4'b0000);
        ireset = 1'b0; iore = 1'b0;
        #1;
        checks++;
        if (d2_eind !== 8'h00 || d2_stall !== 1'b0) begin
            errors++;
            $display("FAIL dut2_rmw eind/stall got %h/%b expected 00/0", d2_eind, d2_stall);
        end
        cyc("rmw_after", 1, 8'hC3, 1'b0, 1'b0, 4'b0000);
        // Counter must restart from scratch: full five stall cycles again.
        iore = 1'b1;
        for (int i = 0; i < 5; i++) cyc($sformatf("rmw_tmo_stall_%0d", i), 0, 8'h00, 1'b1, 1'b0, 4'b0001);
        cyc("rmw_tmo_pulse", 1, 8'hFF, 1'b0, 1'b1, 4'b0001);
        iore = 1'b0; ext_rdy = 4'b1111;
        cyc("rmw_idle", 1, 8'hC3, 1'b0, 1'b0, 4'b0000);
    endtask

    initial begin
        ireset = 1'b1; iore = 1'b0; iowe = 1'b0; adr = 6'h00; dbusout = 8'h00;
        spl_out = 8'h11; sph_out = 8'h22; sreg_out = 8'hA5; dbusin_ext = 8'hC3;
        ext_dat = {8'h44, 8'h33, 8'h22, 8'h11}; ext_rdy = 4'b1111;
        m_rampz = 8'h00;
        @(posedge cp2);
        #1;

        test_reset();
        test_internal_read();
        test_rampz_write();
        test_eind();
        test_ext_wait();
        test_abort();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
